// File: rtl/ram_io_responder_pkg.sv
// Shared constants and address decode for the byte-wide RAM/IO responder.
// The decode helper gives the top and any other user one view of the I/O map.
package ram_io_responder_pkg;

  localparam int          DEFAULT_RAM_ADDR_WIDTH = 17;
  localparam logic [1:0]  IO_REGION              = 2'b11;
  localparam logic [17:0] IO_UART_ADDR           = 18'h30000;
  localparam logic [17:0] IO_CLK_ADDR            = 18'h30004;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_UART,
    SEL_CLK,
    SEL_SNAP1,
    SEL_SNAP2,
    SEL_SNAP3,
    SEL_NONE
  } io_sel_e;

  function automatic io_sel_e decodeAddr(input logic [17:0] addr);
    io_sel_e sel;
    if (addr[17:16] != IO_REGION)            sel = SEL_RAM;
    else if (addr == IO_UART_ADDR)           sel = SEL_UART;
    else if (addr == IO_CLK_ADDR)            sel = SEL_CLK;
    else if (addr == IO_CLK_ADDR + 18'd1)    sel = SEL_SNAP1;
    else if (addr == IO_CLK_ADDR + 18'd2)    sel = SEL_SNAP2;
    else if (addr == IO_CLK_ADDR + 18'd3)    sel = SEL_SNAP3;
    else                                     sel = SEL_NONE;
    return sel;
  endfunction

endpackage

// File: rtl/ram_io_responder_if.sv
// Core-side memory bus: address, write flag and data from the core,
// registered read data and the io_buffer_full flag back to it.
interface ram_io_responder_if;

  logic [31:0] in_addr;
  logic        in_wr;
  logic [7:0]  in_data;
  logic [7:0]  out_data;
  logic        out_io_full;

  modport master (
    output in_addr, in_wr, in_data,
    input  out_data, out_io_full
  );

  modport slave (
    input  in_addr, in_wr, in_data,
    output out_data, out_io_full
  );

endinterface

// File: rtl/ram_io_responder_byte_fifo.sv
// Circular byte FIFO with power-of-two depth. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module byte_fifo #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [7:0]       data_i,
  input  logic             pop_i,
  output logic [7:0]       data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] countNext_o
);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             doPush;
  logic             doPop;

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign data_o      = empty_o ? 8'h00 : mem_q[rdPtr_q];
  assign doPop       = pop_i && !empty_o;
  assign doPush      = push_i && (!full_o || doPop);
  assign countNext_o = count_d;

  always_comb begin
    count_d = count_q;
    if (doPush && !doPop)      count_d = count_q + 1'b1;
    else if (!doPush && doPop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage is never reset; empty reads are masked to zero above.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/ram_io_responder.sv
// Responder for the core's byte bus: byte RAM plus the UART, cycle counter
// and program-stop registers in the I/O window; doubles as the sim memory.
module ram_io_responder
  import ram_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = DEFAULT_RAM_ADDR_WIDTH,
  parameter int TX_DEPTH       = 8,
  parameter int TX_FULL_SLACK  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_io_responder_if.slave    bus,
  input  logic                 in_rx_valid,
  input  logic [7:0]           in_rx_data,
  output logic                 out_rx_pop,
  output logic                 out_tx_valid,
  output logic [7:0]           out_tx_data,
  input  logic                 in_tx_ready,
  output logic                 out_stop,
  output logic                 out_tx_overflow
);

  localparam int               RAM_SIZE   = 1 << RAM_ADDR_WIDTH;
  localparam int               CNT_W      = $clog2(TX_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(TX_DEPTH - TX_FULL_SLACK);

  logic [7:0]                ram [RAM_SIZE];
  logic [RAM_ADDR_WIDTH-1:0] ramIdx;
  io_sel_e                   sel;
  logic                      unusedAddrBits;

  logic [7:0]  data_q, data_d;
  logic [31:0] counter_q, counter_d;
  logic [31:0] snapshot_q, snapshot_d;
  logic        stop_q, stop_d;
  logic        overflow_q, overflow_d;
  logic        ioFull_q, ioFull_d;
  logic        rxPop;

  logic             txPush, txPop, txFull, txEmpty;
  logic [7:0]       txPushData;
  logic [CNT_W-1:0] txCountNext;

  assign ramIdx         = bus.in_addr[RAM_ADDR_WIDTH-1:0];
  assign sel            = decodeAddr(bus.in_addr[17:0]);
  assign unusedAddrBits = ^bus.in_addr[31:18];

  // Every cycle is a transaction: reads choose next out_data, writes hold it.
  always_comb begin
    data_d     = data_q;
    snapshot_d = snapshot_q;
    stop_d     = stop_q;
    txPush     = 1'b0;
    txPushData = bus.in_data;
    rxPop      = 1'b0;
    counter_d  = stop_q ? counter_q : counter_q + 32'd1;
    if (!bus.in_wr) begin
      case (sel)
        SEL_RAM:   data_d = ram[ramIdx];
        SEL_UART: begin
          data_d = in_rx_valid ? in_rx_data : 8'h00;
          rxPop  = in_rx_valid;
        end
        SEL_CLK: begin
          data_d     = counter_q[7:0];
          snapshot_d = counter_q;
        end
        SEL_SNAP1: data_d = snapshot_q[15:8];
        SEL_SNAP2: data_d = snapshot_q[23:16];
        SEL_SNAP3: data_d = snapshot_q[31:24];
        default:   data_d = 8'h00;
      endcase
    end else begin
      case (sel)
        SEL_UART: txPush = (bus.in_data != 8'h00);
        SEL_CLK: begin
          stop_d     = 1'b1;
          txPush     = 1'b1;
          txPushData = 8'h00;
        end
        default: ;
      endcase
    end
  end

  assign txPop      = !txEmpty && in_tx_ready;
  assign overflow_d = overflow_q || (txPush && txFull && !txPop);
  assign ioFull_d   = (txCountNext >= FULL_LEVEL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= 8'h00;
      counter_q  <= 32'd0;
      snapshot_q <= 32'd0;
      stop_q     <= 1'b0;
      overflow_q <= 1'b0;
      ioFull_q   <= 1'b0;
    end else begin
      data_q     <= data_d;
      counter_q  <= counter_d;
      snapshot_q <= snapshot_d;
      stop_q     <= stop_d;
      overflow_q <= overflow_d;
      ioFull_q   <= ioFull_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.in_wr && sel == SEL_RAM) ram[ramIdx] <= bus.in_data;
  end

  byte_fifo #(.DEPTH(TX_DEPTH)) txFifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (txPush),
    .data_i      (txPushData),
    .pop_i       (txPop),
    .data_o      (out_tx_data),
    .full_o      (txFull),
    .empty_o     (txEmpty),
    .countNext_o (txCountNext)
  );

  assign bus.out_data    = data_q;
  assign bus.out_io_full = ioFull_q;
  assign out_rx_pop      = rxPop && !rst;
  assign out_tx_valid    = !txEmpty;
  assign out_stop        = stop_q;
  assign out_tx_overflow = overflow_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder: a behavioural model predicts read data,
// TX stream, flags and counter; scoreboard queues hold the expected values.
module tb_ram_io_responder;

  localparam int          TX_DEPTH   = 8;
  localparam int          FULL_LEVEL = 7;
  localparam logic [31:0] IDLE_ADDR  = 32'h0003_FFFF;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxValid = 1'b0;
  logic [7:0] rxData = 8'h00;
  logic       txReady = 1'b0;
  logic       out_rx_pop, out_tx_valid, out_stop, out_tx_overflow;
  logic [7:0] out_tx_data;

  int checks = 0;
  int failures = 0;

  logic [7:0]  rdExpQ[$];
  logic [7:0]  txExpQ[$];
  logic [7:0]  tbRam[int];
  logic [31:0] tbCycles = 32'd0;
  logic [31:0] tbSnap = 32'd0;
  logic        tbStopped = 1'b0;
  logic        tbOverflow = 1'b0;
  logic [7:0]  lastData = 8'h00;

  ram_io_responder_if busIf();

  ram_io_responder #(
    .RAM_ADDR_WIDTH (17),
    .TX_DEPTH       (TX_DEPTH),
    .TX_FULL_SLACK  (1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (busIf),
    .in_rx_valid     (rxValid),
    .in_rx_data      (rxData),
    .out_rx_pop      (out_rx_pop),
    .out_tx_valid    (out_tx_valid),
    .out_tx_data     (out_tx_data),
    .in_tx_ready     (txReady),
    .out_stop        (out_stop),
    .out_tx_overflow (out_tx_overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelPush(input logic [7:0] d);
    if (txExpQ.size() < TX_DEPTH || txReady) txExpQ.push_back(d);
    else tbOverflow = 1'b1;
  endtask

  task automatic resetModel();
    txExpQ.delete();
    rdExpQ.delete();
    tbCycles   = 32'd0;
    tbSnap     = 32'd0;
    tbStopped  = 1'b0;
    tbOverflow = 1'b0;
    lastData   = 8'h00;
  endtask

  task automatic checkResetState();
    checkOutput("rst_out_data", busIf.out_data, 8'h00);
    checkOutput("rst_tx_valid", out_tx_valid, 1'b0);
    checkOutput("rst_tx_data", out_tx_data, 8'h00);
    checkOutput("rst_io_full", busIf.out_io_full, 1'b0);
    checkOutput("rst_rx_pop", out_rx_pop, 1'b0);
    checkOutput("rst_stop", out_stop, 1'b0);
    checkOutput("rst_overflow", out_tx_overflow, 1'b0);
  endtask

  // Called at a falling edge; drives one bus transaction and checks its results.
  task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [7:0] data);
    logic [7:0] exp;
    logic       expPop;
    logic       stopWrite;
    int         idx;
    exp       = lastData;
    expPop    = 1'b0;
    stopWrite = 1'b0;
    idx       = int'(addr[16:0]);
    busIf.in_addr = addr;
    busIf.in_wr   = wr;
    busIf.in_data = data;
    if (!wr) begin
      if (addr[17:16] != 2'b11) exp = tbRam.exists(idx) ? tbRam[idx] : 8'h00;
      else begin
        case (addr[17:0])
          18'h30000: begin exp = rxValid ? rxData : 8'h00; expPop = rxValid; end
          18'h30004: begin exp = tbCycles[7:0]; tbSnap = tbCycles; end
          18'h30005: exp = tbSnap[15:8];
          18'h30006: exp = tbSnap[23:16];
          18'h30007: exp = tbSnap[31:24];
          default:   exp = 8'h00;
        endcase
      end
    end else begin
      if (addr[17:16] != 2'b11) tbRam[idx] = data;
      else if (addr[17:0] == 18'h30000 && data != 8'h00) modelPush(data);
      else if (addr[17:0] == 18'h30004) begin
        modelPush(8'h00);
        stopWrite = 1'b1;
      end
    end
    rdExpQ.push_back(exp);
    #1;
    checkOutput("rx_pop", out_rx_pop, expPop);
    @(posedge clk);
    #1;
    checkOutput("out_data", busIf.out_data, rdExpQ.pop_front());
    lastData = exp;
    if (!tbStopped) tbCycles++;
    if (stopWrite) tbStopped = 1'b1;
    checkOutput("io_full", busIf.out_io_full, txExpQ.size() >= FULL_LEVEL);
    checkOutput("tx_valid", out_tx_valid, txExpQ.size() != 0);
    checkOutput("tx_overflow", out_tx_overflow, tbOverflow);
    checkOutput("stop", out_stop, tbStopped);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(IDLE_ADDR, 1'b1, 8'h00);
  endtask

  // TX sink: each accepted head byte must be the oldest byte the model queued.
  initial begin
    logic [31:0] expTx;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && out_tx_valid && txReady) begin
        if (txExpQ.size() != 0) expTx = {24'h0, txExpQ.pop_front()};
        else expTx = 32'h100;
        checkOutput("tx_data", out_tx_data, expTx);
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    busIf.in_addr = IDLE_ADDR;
    busIf.in_wr   = 1'b1;
    busIf.in_data = 8'h00;
    #1 rst = 1'b1;
    #1 checkResetState();
    resetModel();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // RAM: write, read-back, write-hold, upper address bits ignored
    applyStimulus(32'h0000_0100, 1'b1, 8'hA5);
    applyStimulus(32'h0000_0100, 1'b0, 8'h00);
    applyStimulus(32'h0001_FFFF, 1'b1, 8'h5A);
    applyStimulus(32'h0000_0000, 1'b1, 8'hC3);
    applyStimulus(32'h0001_FFFF, 1'b0, 8'h00);
    applyStimulus(32'h0000_0000, 1'b0, 8'h00);
    applyStimulus(32'h8000_0100, 1'b0, 8'h00);

    // UART receive with and without a byte waiting
    applyStimulus(32'h0003_0000, 1'b0, 8'h00);
    rxValid = 1'b1;
    rxData  = 8'h37;
    applyStimulus(32'h0003_0000, 1'b0, 8'h00);
    rxValid = 1'b0;

    // TX stream skips zero bytes
    txReady = 1'b1;
    applyStimulus(32'h0003_0000, 1'b1, 8'h41);
    applyStimulus(32'h0003_0000, 1'b1, 8'h00);
    applyStimulus(32'h0003_0000, 1'b1, 8'h42);
    idle(3);

    // Fill with sink stalled, overflow on the ninth byte, then drain
    txReady = 1'b0;
    for (int i = 0; i < 9; i++) applyStimulus(32'h0003_0000, 1'b1, 8'h11 + 8'(i));
    txReady = 1'b1;
    idle(10);

    // Coherent 32-bit counter read after a long run
    idle(300);
    for (int i = 4; i < 8; i++) applyStimulus(32'h0003_0000 + 32'(i), 1'b0, 8'h00);

    // Unmapped I/O reads as zero, writes ignored
    applyStimulus(32'h0003_0008, 1'b1, 8'h99);
    applyStimulus(32'h0003_0008, 1'b0, 8'h00);

    // Program stop: marker queued, counter frozen, bus still served
    txReady = 1'b0;
    applyStimulus(32'h0003_0004, 1'b1, 8'h55);
    idle(3);
    applyStimulus(32'h0003_0004, 1'b0, 8'h00);
    idle(2);
    applyStimulus(32'h0003_0004, 1'b0, 8'h00);
    applyStimulus(32'h0003_0005, 1'b0, 8'h00);
    applyStimulus(32'h0000_0100, 1'b0, 8'h00);

    // Async reset mid-cycle with a receive pop pending on the bus
    busIf.in_addr = 32'h0003_0000;
    busIf.in_wr   = 1'b0;
    rxValid       = 1'b1;
    rxData        = 8'h66;
    #2 rst = 1'b1;
    #1 checkResetState();
    resetModel();
    rxValid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(32'h0003_0004, 1'b0, 8'h00);
    applyStimulus(32'h0003_0004, 1'b0, 8'h00);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_io_responder.md
Name: ram_io_responder

Overview:
- Responder end of the CPU's byte-wide external memory bus: address, byte data-out, write flag from the core, byte data-in back to it.
- Serves a 128 KB byte RAM plus the memory-mapped I/O window at addr[17:16]==2'b11:
  - UART transmit FIFO
  - UART receive byte
  - Free-running cycle counter
  - Program-stop flag
- Drives the core's io_buffer_full input.
- Sits between the cpu top and the board/UART glue; doubles as the simulation memory model.

Parameters:
- RAM_ADDR_WIDTH, 17, RAM index bits; RAM size is 2^RAM_ADDR_WIDTH bytes.
- TX_DEPTH, 8, transmit FIFO entries (power of two, >=4).
- TX_FULL_SLACK, 1, io_full asserts when count >= TX_DEPTH-TX_FULL_SLACK.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_addr  in  32  bus address; only [17:0] decoded
- in_wr  in  1  1 = write, 0 = read
- in_data  in  8  write data from core
- out_data  out  8  read data to core, registered
- out_io_full  out  1  to core io_buffer_full
- in_rx_valid  in  1  receive byte available
- in_rx_data  in  8  receive byte
- out_rx_pop  out  1  one-cycle pulse consuming the receive byte
- out_tx_valid  out  1  transmit FIFO non-empty
- out_tx_data  out  8  transmit FIFO head
- in_tx_ready  in  1  sink accepts head this cycle
- out_stop  out  1  sticky program-stop
- out_tx_overflow  out  1  sticky; a byte was dropped

Behaviour:
- Reset (async assert, released on clk edge):
  - out_data=0, FIFO empty (out_tx_valid=0, out_tx_data=0), out_io_full=0, out_rx_pop=0, out_stop=0, out_tx_overflow=0.
  - counter=0, snapshot=0.
  - RAM contents not reset.
  - A read in flight at reset is discarded.
- Every cycle is a bus transaction; there is no idle encoding. Reads have no side effects except the rx pop and the counter snapshot listed below.
- RAM region (addr[17:16]!=2'b11):
  - Index is addr[RAM_ADDR_WIDTH-1:0].
  - Read: out_data = ram[idx] on the next edge (1-cycle latency).
  - Write: ram[idx]=in_data at the edge; out_data holds its previous value.
  - Read of an address written the previous cycle returns the new value.
- I/O reads, result in out_data next edge:
  - 0x30000: if in_rx_valid, return in_rx_data and pulse out_rx_pop the same cycle; else return 0x00, no pop.
  - 0x30004: return counter[7:0] and latch the full counter into snapshot.
  - 0x30005/6/7: return snapshot bytes 1/2/3. A 4-byte little-endian read is therefore coherent.
  - Any other I/O address returns 0x00.
- I/O writes:
  - 0x30000, data!=0: push to TX FIFO. If the FIFO is full, drop the byte and set out_tx_overflow.
  - 0x30000, data==0: ignored.
  - 0x30004: set out_stop and push 0x00 to TX FIFO (stop marker; dropped and overflow set if full).
  - Other I/O addresses: ignored.
- Counter:
  - 32-bit, +1 per cycle after reset, wraps 0xFFFFFFFF->0.
  - Freezes once out_stop=1.
- TX FIFO:
  - Circular, pointers of log2(TX_DEPTH) bits, count of log2(TX_DEPTH)+1 bits.
  - Pop when out_tx_valid & in_tx_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Push into a full FIFO with a simultaneous pop is accepted.
  - out_io_full is registered, from the post-update count.
- After stop, RAM and I/O accesses continue to be served; only the counter stops.

Decomposition:
- Shared package holds:
  - IO_UART_ADDR=18'h30000, IO_CLK_ADDR=18'h30004.
  - The IO region select constant 2'b11.
  - The default RAM_ADDR_WIDTH.
- Natural sub-module: byte_fifo (parameterised depth; push/pop/full/empty/count), instantiated for TX.
- RAM array and decode stay in this block.

Test Plan:
- Write 0xA5 to 0x00100, then read 0x00100 next cycle -> out_data=0xA5 one cycle after the read address; out_data unchanged during the write cycle.
- Write 0x41, 0x00, 0x42 to 0x30000 with in_tx_ready=1 -> tx stream 0x41, 0x42 only; no overflow.
- Hold in_tx_ready=0 and write 8 non-zero bytes with TX_DEPTH=8 -> out_io_full=1 after the 7th; 9th write dropped with out_tx_overflow=1; after release, the 8 bytes drain in order.
- Run 300 cycles, then read 0x30004..0x30007 on consecutive cycles -> bytes reassemble to the counter value at the 0x30004 read cycle, not later values.
- Read 0x30000 with in_rx_valid=0 -> 0x00, no pop. With in_rx_valid=1 and in_rx_data=0x37 -> out_rx_pop pulse and 0x37 next cycle.
- Write 0x30004, then assert rst mid-sequence -> out_stop=1 and 0x00 queued, counter frozen; on rst all outputs return to reset values immediately (async) and the counter restarts from 0.
